// File: rtl/vitdec_sched_pkg.sv
// Shared types and defaults for the Viterbi job scheduler: FSM states, CFG field layout, register map.
// Pure declarations; no latency and no handshakes of its own.
package vitdec_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CFG    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_UNLOAD = 3'd5
    } state_t;

    localparam int CFG_START_BIT    = 0;
    localparam int DEF_REGS_LSB     = 8;
    localparam int DEF_DONE_BIT     = 31;
    localparam int DEF_CFG_OFS      = 0;
    localparam int DEF_ENC_OFS      = 1;
    localparam int DEF_DEC_OFS      = 9;

    // CFG write value: index of the last loaded ENC_DATA word plus the START bit.
    function automatic logic [31:0] cfg_start_word(input logic [31:0] last_idx, input int lsb);
        return (last_idx << lsb) | (32'd1 << CFG_START_BIT);
    endfunction

endpackage

// File: rtl/vitdec_sched_if.sv
// Requester, decoder register bus and decoded-output signals of the scheduler, grouped in one bundle.
// master = scheduler side; slave = requesters, decoder and downstream sink.
interface vitdec_sched_if #(parameter int N_REQ = 4);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_last;

    logic [7:0]          dec_addr;
    logic                dec_wr;
    logic [31:0]         dec_wdata;
    logic                dec_rd;
    logic [31:0]         dec_rdata;
    logic                dec_rvalid;

    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic [IW-1:0]       out_id;
    logic                out_last;

    modport master (
        input  req_valid, req_data, req_last, dec_rdata, dec_rvalid, out_ready,
        output req_ready, dec_addr, dec_wr, dec_wdata, dec_rd,
               out_valid, out_data, out_id, out_last
    );

    modport slave (
        output req_valid, req_data, req_last, dec_rdata, dec_rvalid, out_ready,
        input  req_ready, dec_addr, dec_wr, dec_wdata, dec_rd,
               out_valid, out_data, out_id, out_last
    );
endinterface

// File: rtl/vitdec_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching from pointer+1; pointer moves to the winner on i_en.
// No backpressure; grant is valid in the same cycle as the requests.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] r_ptr;
    int            w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(r_ptr) + k) % N;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = IW'(w_cand);
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_ptr <= '0;
        else if (i_en && o_any)
            r_ptr <= o_idx;
    end
endmodule

// File: rtl/vitdec_sched.sv
// Shares one register-mapped Viterbi decoder among N_REQ channels: load ENC words, START, poll DONE, drain DEC words.
// Backpressure: req_ready only for the granted channel in LOAD; output reads wait for out handshake. VITDEC_SCHED_TIMEOUT_EN adds a DONE-wait timeout.
module vitdec_sched
    import vitdec_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_WORDS = 8,
    parameter int CFG_OFS   = DEF_CFG_OFS,
    parameter int ENC_OFS   = DEF_ENC_OFS,
    parameter int DEC_OFS   = DEF_DEC_OFS,
    parameter int DONE_BIT  = DEF_DONE_BIT,
    parameter int REGS_LSB  = DEF_REGS_LSB,
    parameter int POLL_GAP  = 4,
    parameter int TMO_CYC   = 65535
) (
    input  logic           clk,
    input  logic           resetn,
    vitdec_sched_if.master vif,
    output logic           busy,
    output logic           err_ovf,
    output logic           err_tmo
);
    localparam int IW = $clog2(N_REQ);
    localparam int NW = $clog2(MAX_WORDS + 1);
    localparam int GW = $clog2(POLL_GAP + 1) + 1;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_gnt;
    logic [NW-1:0]   r_n, r_i, w_m;
    logic [GW-1:0]   r_gap;
    logic            r_pend, r_ovld, r_olast, r_ovf;
    logic [31:0]     r_odat;
    logic [N_REQ-1:0] w_gnt_oh;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_any, w_acc, w_wr_enc, w_poll, w_done, w_ud_rd, w_ohs, w_tmo_hit;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .i_req  (vif.req_valid),
        .i_en   (r_state == ST_ARB),
        .o_gnt  (w_gnt_oh),
        .o_idx  (w_gnt_idx),
        .o_any  (w_any)
    );

    // r_n saturates at MAX_WORDS, so it already holds min(n, MAX_WORDS).
    assign w_m      = NW'(({1'b0, r_n} + 1'b1) >> 1);
    assign w_acc    = (r_state == ST_LOAD) && vif.req_valid[r_gnt];
    assign w_wr_enc = w_acc && (32'(r_n) < MAX_WORDS);
    assign w_poll   = (r_state == ST_WAIT) && !r_pend && (r_gap == GW'(POLL_GAP));
    assign w_done   = (r_state == ST_WAIT) && r_pend && vif.dec_rvalid && vif.dec_rdata[DONE_BIT];
    assign w_ud_rd  = (r_state == ST_UNLOAD) && !r_pend && !r_ovld;
    assign w_ohs    = r_ovld && vif.out_ready;

    assign busy          = (r_state != ST_IDLE);
    assign err_ovf       = r_ovf;
    assign vif.out_valid = r_ovld;
    assign vif.out_data  = r_odat;
    assign vif.out_id    = r_gnt;
    assign vif.out_last  = r_olast;

`ifdef VITDEC_SCHED_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_tmo;

    assign w_tmo_hit = (r_state == ST_WAIT) && (r_tmo_cnt == 32'(TMO_CYC));
    assign err_tmo   = r_tmo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == ST_WAIT) ? r_tmo_cnt + 32'd1 : 32'd0;
            if (w_tmo_hit && !w_done)
                r_tmo <= 1'b1;
        end
    end
`else
    localparam int unused_tmo_cyc = TMO_CYC;
    assign w_tmo_hit = 1'b0;
    assign err_tmo   = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        vif.req_ready = '0;
        vif.dec_addr  = '0;
        vif.dec_wr    = 1'b0;
        vif.dec_wdata = '0;
        vif.dec_rd    = 1'b0;
        case (r_state)
            ST_IDLE:   if (|vif.req_valid) w_next = ST_ARB;
            ST_ARB:    w_next = w_any ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                vif.req_ready[r_gnt] = 1'b1;
                if (w_wr_enc) begin
                    vif.dec_wr    = 1'b1;
                    vif.dec_addr  = 8'(ENC_OFS) + 8'(r_n);
                    vif.dec_wdata = vif.req_data[32*r_gnt +: 32];
                end
                if (w_acc && vif.req_last[r_gnt])
                    w_next = ST_CFG;
            end
            ST_CFG: begin
                vif.dec_wr    = 1'b1;
                vif.dec_addr  = 8'(CFG_OFS);
                vif.dec_wdata = cfg_start_word(32'(r_n) - 32'd1, REGS_LSB);
                w_next        = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_poll) begin
                    vif.dec_rd   = 1'b1;
                    vif.dec_addr = 8'(CFG_OFS);
                end
                if (w_done)
                    w_next = ST_UNLOAD;
                else if (w_tmo_hit)
                    w_next = ST_IDLE;
            end
            ST_UNLOAD: begin
                if (w_ud_rd) begin
                    vif.dec_rd   = 1'b1;
                    vif.dec_addr = 8'(DEC_OFS) + 8'(r_i);
                end
                if (w_ohs && r_olast)
                    w_next = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gnt   <= '0;
            r_n     <= '0;
            r_i     <= '0;
            r_gap   <= '0;
            r_pend  <= 1'b0;
            r_ovld  <= 1'b0;
            r_olast <= 1'b0;
            r_odat  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_any) r_gnt <= w_gnt_idx;
                    r_n    <= '0;
                    r_i    <= '0;
                    r_pend <= 1'b0;
                    r_ovld <= 1'b0;
                end
                ST_LOAD: begin
                    if (w_wr_enc)   r_n   <= r_n + 1'b1;
                    else if (w_acc) r_ovf <= 1'b1;
                end
                ST_CFG: begin
                    r_gap  <= '0;
                    r_pend <= 1'b0;
                end
                ST_WAIT: begin
                    if (r_pend) begin
                        if (vif.dec_rvalid) begin
                            r_pend <= 1'b0;
                            r_gap  <= '0;
                        end
                    end else if (w_poll)
                        r_pend <= 1'b1;
                    else
                        r_gap <= r_gap + 1'b1;
                end
                ST_UNLOAD: begin
                    if (w_ud_rd) r_pend <= 1'b1;
                    if (r_pend && vif.dec_rvalid) begin
                        r_pend  <= 1'b0;
                        r_ovld  <= 1'b1;
                        r_odat  <= vif.dec_rdata;
                        r_olast <= (r_i == w_m - 1'b1);
                    end
                    if (w_ohs) begin
                        r_ovld  <= 1'b0;
                        r_olast <= 1'b0;
                        r_i     <= r_i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vitdec_sched.sv
// Directed bench for vitdec_sched with a small decoder register model; expected values are hand-computed constants.
module tb_vitdec_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy, err_ovf, err_tmo;

    vitdec_sched_if #(.N_REQ(N)) vif ();

`ifdef VITDEC_SCHED_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65535;
`endif

    vitdec_sched #(.N_REQ(N), .MAX_WORDS(8), .POLL_GAP(4), .TMO_CYC(TMO)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .vif     (vif),
        .busy    (busy),
        .err_ovf (err_ovf),
        .err_tmo (err_tmo)
    );

    always #5 clk = ~clk;

    logic        t_vld [N];
    logic [31:0] t_dat [N];
    logic        t_last[N];

    always_comb begin
        for (int c = 0; c < N; c++) begin
            vif.req_valid[c]         = t_vld[c];
            vif.req_last[c]          = t_last[c];
            vif.req_data[32*c +: 32] = t_dat[c];
        end
    end

    // decoder register model: DONE on the done_after-th poll (0 = never)
    int          done_after = 1;
    int          polls = 0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    assign vif.dec_rvalid = m_rvalid;
    assign vif.dec_rdata  = m_rdata;

    always @(posedge clk) begin
        m_rvalid <= 1'b0;
        m_rdata  <= '0;
        if (vif.dec_wr && vif.dec_addr == 8'd0) polls <= 0;
        if (vif.dec_rd) begin
            m_rvalid <= 1'b1;
            if (vif.dec_addr == 8'd0) begin
                polls   <= polls + 1;
                m_rdata <= (done_after != 0 && polls + 1 >= done_after) ? 32'h8000_0000 : 32'h0;
            end else
                m_rdata <= 32'hA5A5_0000 | 32'(vif.dec_addr);
        end
    end

    logic [31:0] wr_a[$], wr_d[$], rd_a[$], o_d[$], o_id[$], o_last[$];
    int both_cnt = 0, stray_cnt = 0;

    always @(posedge clk) if (resetn) begin
        if (vif.dec_wr) begin wr_a.push_back(32'(vif.dec_addr)); wr_d.push_back(vif.dec_wdata); end
        if (vif.dec_rd) rd_a.push_back(32'(vif.dec_addr));
        if (vif.dec_wr && vif.dec_rd) both_cnt++;
        if (!vif.dec_wr && !vif.dec_rd && (vif.dec_addr != 0 || vif.dec_wdata != 0)) stray_cnt++;
        if (vif.out_valid && vif.out_ready) begin
            o_d.push_back(vif.out_data);
            o_id.push_back(32'(vif.out_id));
            o_last.push_back(32'(vif.out_last));
        end
    end

    int n_err = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clr_logs();
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        o_d.delete(); o_id.delete(); o_last.delete();
    endtask

    task automatic push(input int ch, input int nw, input logic [31:0] base, input string tag);
        int cnt;
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            t_vld[ch]  = 1'b1;
            t_dat[ch]  = base * 32'(w + 1);
            t_last[ch] = (w == nw - 1);
            cnt = 0;
            while (!vif.req_ready[ch] && cnt < 2000) begin @(negedge clk); cnt++; end
            if (cnt >= 2000) begin
                chk({tag, " ready"}, 32'(vif.req_ready[ch]), 32'd1);
                t_vld[ch] = 1'b0;
                return;
            end
        end
        @(negedge clk);
        t_vld[ch]  = 1'b0;
        t_last[ch] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cnt = 0;
        while (busy && cnt < 2000) begin @(negedge clk); cnt++; end
        if (cnt >= 2000) chk({tag, " idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d0;
        int          rd0, unstable;
        for (int c = 0; c < N; c++) begin t_vld[c] = 0; t_dat[c] = 0; t_last[c] = 0; end
        vif.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst busy",      32'(busy), 0);
        chk("rst err_ovf",   32'(err_ovf), 0);
        chk("rst err_tmo",   32'(err_tmo), 0);
        chk("rst req_ready", 32'(vif.req_ready), 0);
        chk("rst dec_wr",    32'(vif.dec_wr), 0);
        chk("rst dec_rd",    32'(vif.dec_rd), 0);
        chk("rst out_valid", 32'(vif.out_valid), 0);
        @(negedge clk); resetn = 1'b1;

        // 1: ch0, 3 words, DONE on second poll
        done_after = 2;
        clr_logs();
        push(0, 3, 32'h1111_1111, "t1");
        wait_idle("t1");
        chk("t1 wr cnt", 32'(wr_a.size()), 4);
        chk("t1 wr0 a", qv(wr_a, 0), 1); chk("t1 wr0 d", qv(wr_d, 0), 32'h1111_1111);
        chk("t1 wr1 a", qv(wr_a, 1), 2); chk("t1 wr1 d", qv(wr_d, 1), 32'h2222_2222);
        chk("t1 wr2 a", qv(wr_a, 2), 3); chk("t1 wr2 d", qv(wr_d, 2), 32'h3333_3333);
        chk("t1 cfg a", qv(wr_a, 3), 0); chk("t1 cfg d", qv(wr_d, 3), 32'h0000_0201);
        chk("t1 rd cnt", 32'(rd_a.size()), 4);
        chk("t1 poll0", qv(rd_a, 0), 0); chk("t1 poll1", qv(rd_a, 1), 0);
        chk("t1 dec0",  qv(rd_a, 2), 9); chk("t1 dec1",  qv(rd_a, 3), 10);
        chk("t1 out cnt", 32'(o_d.size()), 2);
        chk("t1 out0 d", qv(o_d, 0), 32'hA5A5_0009); chk("t1 out0 id", qv(o_id, 0), 0);
        chk("t1 out0 last", qv(o_last, 0), 0);
        chk("t1 out1 d", qv(o_d, 1), 32'hA5A5_000A); chk("t1 out1 last", qv(o_last, 1), 1);

        // 2: all channels at once, 1 word each -> rotation 1,2,3,0
        done_after = 1;
        clr_logs();
        fork
            push(0, 1, 32'hC0DE_0000, "t2c0");
            push(1, 1, 32'hC0DE_0001, "t2c1");
            push(2, 1, 32'hC0DE_0002, "t2c2");
            push(3, 1, 32'hC0DE_0003, "t2c3");
        join
        wait_idle("t2");
        chk("t2 wr cnt", 32'(wr_a.size()), 8);
        chk("t2 out cnt", 32'(o_id.size()), 4);
        chk("t2 grant0", qv(o_id, 0), 1); chk("t2 grant1", qv(o_id, 1), 2);
        chk("t2 grant2", qv(o_id, 2), 3); chk("t2 grant3", qv(o_id, 3), 0);
        chk("t2 enc0", qv(wr_d, 0), 32'hC0DE_0001); chk("t2 enc3", qv(wr_d, 6), 32'hC0DE_0000);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t2 cfg%0d", j), qv(wr_d, 2*j + 1), 32'h0000_0001);
            chk($sformatf("t2 last%0d", j), qv(o_last, j), 1);
        end

        // 3: ch2 sends 10 words into an 8-word buffer
        clr_logs();
        push(2, 10, 32'h0101_0101, "t3");
        wait_idle("t3");
        chk("t3 err_ovf", 32'(err_ovf), 1);
        chk("t3 wr cnt", 32'(wr_a.size()), 9);
        chk("t3 enc7 a", qv(wr_a, 7), 8); chk("t3 enc7 d", qv(wr_d, 7), 32'h0808_0808);
        chk("t3 cfg d", qv(wr_d, 8), 32'h0000_0701);
        chk("t3 out cnt", 32'(o_d.size()), 4);
        chk("t3 out3 d", qv(o_d, 3), 32'hA5A5_000C); chk("t3 out3 last", qv(o_last, 3), 1);
        chk("t3 out2 last", qv(o_last, 2), 0); chk("t3 out id", qv(o_id, 0), 2);

        // 4: sink stalls 20 cycles during UNLOAD
        clr_logs();
        vif.out_ready = 1'b0;
        push(1, 4, 32'h4000_0000, "t4");
        begin
            int cnt = 0;
            while (!vif.out_valid && cnt < 500) begin @(negedge clk); cnt++; end
            chk("t4 out_valid", 32'(vif.out_valid), 1);
        end
        d0 = vif.out_data; rd0 = rd_a.size(); unstable = 0;
        chk("t4 held d", d0, 32'hA5A5_0009);
        chk("t4 held id", 32'(vif.out_id), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vif.out_data !== d0 || vif.out_id !== 2'd1 || !vif.out_valid) unstable++;
        end
        chk("t4 stable", 32'(unstable), 0);
        chk("t4 no extra rd", 32'(rd_a.size()), 32'(rd0));
        vif.out_ready = 1'b1;
        wait_idle("t4");
        chk("t4 out cnt", 32'(o_d.size()), 2);
        chk("t4 out1 d", qv(o_d, 1), 32'hA5A5_000A);

`ifdef VITDEC_SCHED_TIMEOUT_EN
        // 5: DONE never set
        clr_logs();
        done_after = 0;
        push(0, 2, 32'h5000_0000, "t5");
        wait_idle("t5");
        chk("t5 err_tmo", 32'(err_tmo), 1);
        chk("t5 no out", 32'(o_d.size()), 0);
        done_after = 1;
`else
        chk("t5 err_tmo tied", 32'(err_tmo), 0);
`endif

        // 6: reset in the middle of LOAD, then a clean job
        @(negedge clk);
        t_vld[3] = 1'b1; t_dat[3] = 32'h3333_0000; t_last[3] = 1'b0;
        begin
            int cnt = 0;
            while (!vif.req_ready[3] && cnt < 100) begin @(negedge clk); cnt++; end
            chk("t6 ready", 32'(vif.req_ready[3]), 1);
        end
        @(negedge clk); @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("t6 busy",      32'(busy), 0);
        chk("t6 req_ready", 32'(vif.req_ready), 0);
        chk("t6 dec_wr",    32'(vif.dec_wr), 0);
        chk("t6 dec_addr",  32'(vif.dec_addr), 0);
        chk("t6 err_ovf",   32'(err_ovf), 0);
        chk("t6 err_tmo",   32'(err_tmo), 0);
        chk("t6 out_valid", 32'(vif.out_valid), 0);
        t_vld[3] = 1'b0;
        @(negedge clk); resetn = 1'b1;
        clr_logs();
        push(3, 1, 32'h6000_0006, "t6");
        wait_idle("t6");
        chk("t6 wr cnt", 32'(wr_a.size()), 2);
        chk("t6 enc a", qv(wr_a, 0), 1); chk("t6 enc d", qv(wr_d, 0), 32'h6000_0006);
        chk("t6 cfg d", qv(wr_d, 1), 32'h0000_0001);
        chk("t6 out id", qv(o_id, 0), 3);

        chk("bus one strobe", 32'(both_cnt), 0);
        chk("bus idle zero",  32'(stray_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vitdec_sched.md
Name: vitdec_sched

Overview:
- Job scheduler that shares one register-mapped Viterbi decoder (K=7, rate 1/2) between N_REQ requester channels.
- Round-robin picks a requester, streams its encoded words into the decoder ENC_DATA registers, writes CFG with START, and polls DONE.
- On completion, reads back the DEC_DATA words and emits them as a tagged output stream.
- Sits between the channel demodulators and the decoder's register bus, as that bus's only master.

Parameters:
- N_REQ, 4, number of requester channels (2..8)
- MAX_WORDS, 8, decoder encoded-word buffer depth (VIT_BUF_SIZE)
- CFG_OFS, 0, word offset of the decoder CFG register
- ENC_OFS, 1, word offset of ENC_DATA[0]
- DEC_OFS, 9, word offset of DEC_DATA[0]
- DONE_BIT, 31, bit index of DONE in CFG readback
- REGS_LSB, 8, LSB of the DAT_REGS field in CFG
- POLL_GAP, 4, idle cycles between START and the first DONE poll, and between successive polls
- TMO_CYC, 65535, WAIT-state timeout in cycles (used only when the optional feature is enabled)

Ports:
- clk, in, 1, clock
- resetn, in, 1, asynchronous active-low reset
- req_valid, in, N_REQ, per-channel encoded-word valid
- req_ready, out, N_REQ, per-channel ready
- req_data, in, 32*N_REQ, encoded words: 16 bit-pairs, pair 0 in bits [1:0]
- req_last, in, N_REQ, last word of the job
- dec_addr, out, 8, decoder register word address
- dec_wr, out, 1, write strobe (1 cycle)
- dec_wdata, out, 32, write data
- dec_rd, out, 1, read strobe (1 cycle)
- dec_rdata, in, 32, read data
- dec_rvalid, in, 1, read data valid (1 cycle after dec_rd)
- out_valid, out, 1, decoded word valid
- out_ready, in, 1, downstream ready
- out_data, out, 32, decoded word
- out_id, out, clog2(N_REQ), source channel
- out_last, out, 1, last decoded word of the job
- busy, out, 1, job in progress
- err_ovf, out, 1, sticky: a job exceeded MAX_WORDS
- err_tmo, out, 1, sticky: DONE wait timed out

Behaviour:
- Reset: all outputs 0, FSM = IDLE, round-robin pointer = 0, word counter = 0. Reset asserted mid-job aborts immediately; no further bus strobes are issued.
- Bus: at most one strobe (dec_wr or dec_rd) per cycle. dec_addr and dec_wdata are valid only with a strobe and are 0 otherwise.
- IDLE: when any req_valid is set, go to ARB.
- ARB (1 cycle): round-robin grant, searching from pointer+1. The pointer is updated to the granted channel. Clear word count n.
- LOAD: req_ready[g]=1 only for the granted channel g.
  - Each accepted word with n<MAX_WORDS produces dec_wr to ENC_OFS+n with that data in the same cycle, then n++.
  - Words beyond MAX_WORDS are accepted and dropped; set err_ovf.
  - On an accepted req_last, go to CFG.
  - No back-pressure other than req_ready.
- CFG (1 cycle): dec_wr to CFG_OFS with data = ((min(n,MAX_WORDS)-1) << REGS_LSB) | 1 (START), then go to WAIT.
- WAIT: after POLL_GAP idle cycles, issue dec_rd to CFG_OFS.
  - On dec_rvalid with dec_rdata[DONE_BIT]=1, go to UNLOAD.
  - Otherwise wait POLL_GAP cycles and repeat.
- UNLOAD: m = ceil(n/2) decoded words.
  - For i=0..m-1: dec_rd to DEC_OFS+i, capture data on rvalid, present on out_*; out_last=1 when i=m-1.
  - The next read is issued only after out handshake; out_* are held stable while out_ready=0.
  - After the last handshake, return to IDLE. busy=0 only in IDLE.
- Simultaneous requests: strict rotation; a channel requesting continuously waits at most N_REQ-1 jobs.
- n=1 (single word): DAT_REGS=0, m=1.

Optional Feature:
- Macro: VITDEC_SCHED_TIMEOUT_EN.
- Defined: a WAIT cycle counter runs. When it reaches TMO_CYC, set err_tmo, skip UNLOAD, and return to IDLE (no out_* emitted for that job).
- Undefined: no counter; WAIT polls indefinitely and err_tmo is tied to 0.

Decomposition:
- Package vitdec_sched_pkg: FSM state enum (IDLE, ARB, LOAD, CFG, WAIT, UNLOAD), CFG field position constants, default register offsets.
- Sub-module rr_arbiter (N_REQ requests, grant one-hot + index, pointer update on enable).
- Remainder (FSM, counters, bus sequencing) in vitdec_sched.

Test Plan:
- Ch0, 3 words (0x11111111..0x33333333, last on 3rd); decoder model returns DONE on 2nd poll -> dec_wr ENC_OFS+0..2, CFG write 0x201, 2 DEC reads, 2 out words with id=0, last on 2nd.
- All 4 channels valid together, 1 word each -> grant order 1,2,3,0; one CFG write 0x001 per job; busy never drops between back-to-back jobs except in IDLE cycles.
- Ch2 sends 10 words with MAX_WORDS=8 -> 8 ENC writes, err_ovf=1, CFG DAT_REGS=7, 4 out words.
- out_ready held low 20 cycles during UNLOAD -> out_data/out_id stable, no extra dec_rd issued.
- With VITDEC_SCHED_TIMEOUT_EN, TMO_CYC=100, DONE never set -> err_tmo=1 about 100 cycles after CFG, FSM to IDLE, no out_valid.
- resetn low during LOAD -> all outputs 0 asynchronously, req_ready=0; after release, the next job starts cleanly from ARB.
